// File: rtl/chromosome_eval_engine.sv
// chromosome_eval_engine
// Evaluates one chromosome by driving an external phenotype with a stored
// input sequence. Each vector is held for a programmable dwell time. After a
// short settle window the phenotype outputs are compared against the expected
// vector under a care mask. Per-output-bit error sums build up in one of two
// counting modes. A chromosome that scores zero is re-run up to NUM_RETRIES
// times. A run ends early once the total error reaches a programmable limit.
// Every sampled cycle is logged to an external trace memory.
//
// Ports:
//   iClock, iReset_n        clock (rising edge), asynchronous active-low reset
//   iStart / oReady         start request, accepted only in IDLE
//   iAck / oDone            result acknowledge, accepted only in DONE
//   iInputSequence          MAX_SEQ packed input vectors
//   iExpectedOutput         MAX_SEQ packed expected outputs
//   iValidMask              MAX_SEQ packed care masks (1 = compared)
//   iSequencesToProcess     vector count N (clamped to MAX_SEQ)
//   iDwellCycles            cycles per vector D (0 is treated as 1)
//   iErrorLimit             abort threshold on the total error (0 = no abort)
//   iCountMode              0 = per-vector boolean, 1 = mismatching-cycle count
//   oChromIn / iChromOut    phenotype drive and response
//   oClearChrom             clears the phenotype description (CLEAR state)
//   oAborted                run stopped on the error limit
//   oLogOverflow            trace memory full; further writes suppressed
//   oState                  IDLE=0 CLEAR=1 SETTLE=2 SAMPLE=3 CHECK=4 DONE=5
//   oErrorSums, oTotalError per-bit error sums and their total
//   oRetriesUsed            completed retry passes
//   oMemAddr/oMemData/oMemWrite  trace memory write port
module chromosome_eval_engine #(
    parameter int IN_WIDTH         = 8,
    parameter int OUT_WIDTH        = 8,
    parameter int MAX_SEQ          = 64,
    parameter int ERR_W            = 32,
    parameter int ADDR_W           = 15,
    parameter int CYCLES_TO_IGNORE = 10,
    parameter int NUM_RETRIES      = 2
) (
    input  logic                                iClock,
    input  logic                                iReset_n,
    input  logic                                iStart,
    input  logic                                iAck,
    input  logic [MAX_SEQ*IN_WIDTH-1:0]         iInputSequence,
    input  logic [MAX_SEQ*OUT_WIDTH-1:0]        iExpectedOutput,
    input  logic [MAX_SEQ*OUT_WIDTH-1:0]        iValidMask,
    input  logic [7:0]                          iSequencesToProcess,
    input  logic [15:0]                         iDwellCycles,
    input  logic [ERR_W+2:0]                    iErrorLimit,
    input  logic                                iCountMode,
    output logic [IN_WIDTH-1:0]                 oChromIn,
    input  logic [OUT_WIDTH-1:0]                iChromOut,
    output logic                                oClearChrom,
    output logic                                oReady,
    output logic                                oDone,
    output logic                                oAborted,
    output logic                                oLogOverflow,
    output logic [2:0]                          oState,
    output logic [OUT_WIDTH*ERR_W-1:0]          oErrorSums,
    output logic [ERR_W+2:0]                    oTotalError,
    output logic [1:0]                          oRetriesUsed,
    output logic [ADDR_W-1:0]                   oMemAddr,
    output logic [IN_WIDTH+8+2*OUT_WIDTH-1:0]   oMemData,
    output logic                                oMemWrite
);

    // Per-vector sample count is bounded by the 16-bit dwell time.
    localparam int SUM_W = 16;
    localparam int TOT_W = ERR_W + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, nextState;

    logic [7:0]           seqCount;
    logic [7:0]           idx;
    logic [15:0]          dwell;
    logic [15:0]          cycleCnt;
    logic [TOT_W-1:0]     errLimit;
    logic                 countMode;
    logic [SUM_W-1:0]     sampleSum [OUT_WIDTH];
    logic [ERR_W-1:0]     errSum    [OUT_WIDTH];
    logic [1:0]           retries;
    logic [ADDR_W-1:0]    memAddr;
    logic                 aborted;
    logic                 logOverflow;
    logic [IN_WIDTH-1:0]  chromIn;

    logic [7:0]           startCount;
    logic [OUT_WIDTH-1:0] expVec;
    logic [OUT_WIDTH-1:0] maskVec;
    logic [OUT_WIDTH-1:0] mismatch;
    logic                 sampling;
    logic                 lastCycle;
    logic                 lastVector;
    logic                 abortNow;
    logic                 retryNow;
    logic [SUM_W-1:0]     sampleNext [OUT_WIDTH];
    logic [ERR_W-1:0]     errNext    [OUT_WIDTH];
    logic [ERR_W-1:0]     errInc;
    logic [ERR_W:0]       errWide;
    logic [TOT_W-1:0]     totalNow;
    logic [TOT_W-1:0]     totalNext;

    // Datapath: mismatch detection, saturating sums and the commit values
    // that become visible on the last sample cycle of a vector.
    always_comb begin
        startCount = (iSequencesToProcess > 8'(MAX_SEQ)) ? 8'(MAX_SEQ) : iSequencesToProcess;
        expVec     = iExpectedOutput[idx*OUT_WIDTH +: OUT_WIDTH];
        maskVec    = iValidMask[idx*OUT_WIDTH +: OUT_WIDTH];
        mismatch   = (iChromOut ^ expVec) & maskVec;
        sampling   = (cycleCnt >= 16'(CYCLES_TO_IGNORE));
        lastCycle  = (cycleCnt == dwell - 16'd1);
        lastVector = (idx == seqCount - 8'd1);
        errInc     = '0;
        errWide    = '0;
        totalNow   = '0;
        totalNext  = '0;
        for (int unsigned b = 0; b < OUT_WIDTH; b++) begin
            sampleNext[b] = sampleSum[b];
            if (sampling && mismatch[b] && (sampleSum[b] != '1))
                sampleNext[b] = sampleSum[b] + 1'b1;
            errInc     = countMode ? ERR_W'(sampleNext[b]) : ERR_W'(sampleNext[b] != '0);
            errWide    = {1'b0, errSum[b]} + {1'b0, errInc};
            errNext[b] = errWide[ERR_W] ? '1 : errWide[ERR_W-1:0];
            totalNow   = totalNow + TOT_W'(errSum[b]);
            totalNext  = totalNext + TOT_W'(errNext[b]);
        end
        abortNow = lastCycle && (errLimit != '0) && (totalNext >= errLimit);
        retryNow = (totalNow == '0) && (retries < 2'(NUM_RETRIES));
    end

    // State register
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:   if (iStart) nextState = (startCount == 8'd0) ? DONE : CLEAR;
            CLEAR:  nextState = SETTLE;
            SETTLE: nextState = SAMPLE;
            SAMPLE: begin
                if (lastCycle) begin
                    if (abortNow)
                        nextState = DONE;
                    else if (lastVector)
                        nextState = CHECK;
                    else
                        nextState = SETTLE;
                end
            end
            CHECK:  nextState = retryNow ? SETTLE : DONE;
            DONE:   if (iAck) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            seqCount    <= '0;
            idx         <= '0;
            dwell       <= '0;
            cycleCnt    <= '0;
            errLimit    <= '0;
            countMode   <= 1'b0;
            retries     <= '0;
            memAddr     <= '0;
            aborted     <= 1'b0;
            logOverflow <= 1'b0;
            chromIn     <= '0;
            for (int unsigned b = 0; b < OUT_WIDTH; b++) begin
                sampleSum[b] <= '0;
                errSum[b]    <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        seqCount    <= startCount;
                        dwell       <= (iDwellCycles == 16'd0) ? 16'd1 : iDwellCycles;
                        errLimit    <= iErrorLimit;
                        countMode   <= iCountMode;
                        retries     <= '0;
                        idx         <= '0;
                        memAddr     <= '0;
                        aborted     <= 1'b0;
                        logOverflow <= 1'b0;
                        for (int unsigned b = 0; b < OUT_WIDTH; b++)
                            errSum[b] <= '0;
                    end
                end
                SETTLE: begin
                    chromIn  <= iInputSequence[idx*IN_WIDTH +: IN_WIDTH];
                    cycleCnt <= '0;
                    for (int unsigned b = 0; b < OUT_WIDTH; b++)
                        sampleSum[b] <= '0;
                end
                SAMPLE: begin
                    cycleCnt <= cycleCnt + 16'd1;
                    for (int unsigned b = 0; b < OUT_WIDTH; b++)
                        sampleSum[b] <= sampleNext[b];
                    // The last address is written once, then held.
                    if (!logOverflow) begin
                        if (memAddr == '1)
                            logOverflow <= 1'b1;
                        else
                            memAddr <= memAddr + 1'b1;
                    end
                    if (lastCycle) begin
                        for (int unsigned b = 0; b < OUT_WIDTH; b++)
                            errSum[b] <= errNext[b];
                        if (abortNow)
                            aborted <= 1'b1;
                        else if (!lastVector)
                            idx <= idx + 8'd1;
                    end
                end
                CHECK: begin
                    if (retryNow) begin
                        retries     <= retries + 2'd1;
                        idx         <= '0;
                        memAddr     <= '0;
                        logOverflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        oReady       = (state == IDLE);
        oDone        = (state == DONE);
        oClearChrom  = (state == CLEAR);
        oMemWrite    = (state == SAMPLE) && !logOverflow;
        oState       = state;
        oChromIn     = chromIn;
        oAborted     = aborted;
        oLogOverflow = logOverflow;
        oRetriesUsed = retries;
        oMemAddr     = memAddr;
        oTotalError  = totalNow;
        oMemData     = {chromIn, idx, expVec, iChromOut};
        oErrorSums   = '0;
        for (int unsigned b = 0; b < OUT_WIDTH; b++)
            oErrorSums[b*ERR_W +: ERR_W] = errSum[b];
    end

endmodule

// File: tb/tb_chromosome_eval_engine.sv
// Testbench for chromosome_eval_engine: a small phenotype model answers the
// engine, expected run results go into a scoreboard queue at start time and
// are popped and compared when oDone rises.
module tb_chromosome_eval_engine;

    localparam int MS = 64;
    localparam int IW = 8;
    localparam int OW = 8;
    localparam int EW = 32;

    typedef struct {
        int          lat;
        logic [34:0] total;
        logic [31:0] err3;
        logic        aborted;
        logic [1:0]  retries;
        logic [14:0] addr;
    } exp_t;

    exp_t sb[$];

    logic iClock = 1'b0;
    always #5 iClock = ~iClock;

    logic               iReset_n;
    logic               iStart;
    logic               iAck;
    logic [MS*IW-1:0]   iInputSequence;
    logic [MS*OW-1:0]   iExpectedOutput;
    logic [MS*OW-1:0]   iValidMask;
    logic [7:0]         iSequencesToProcess;
    logic [15:0]        iDwellCycles;
    logic [34:0]        iErrorLimit;
    logic               iCountMode;
    logic [IW-1:0]      oChromIn;
    logic [OW-1:0]      iChromOut;
    logic               oClearChrom, oReady, oDone, oAborted, oLogOverflow;
    logic [2:0]         oState;
    logic [OW*EW-1:0]   oErrorSums;
    logic [34:0]        oTotalError;
    logic [1:0]         oRetriesUsed;
    logic [14:0]        oMemAddr;
    logic [IW+8+2*OW-1:0] oMemData;
    logic               oMemWrite;

    logic [IW-1:0]      oChromIn2;
    logic               oClearChrom2, oReady2, oDone2, oAborted2, oLogOverflow2;
    logic [2:0]         oState2;
    logic [OW*EW-1:0]   oErrorSums2;
    logic [34:0]        oTotalError2;
    logic [1:0]         oRetriesUsed2;
    logic [5:0]         oMemAddr2;
    logic [IW+8+2*OW-1:0] oMemData2;
    logic               oMemWrite2;

    logic [7:0] invMask;
    int nTests = 0;
    int nFail  = 0;
    int writes2 = 0;

    function automatic logic [7:0] pheno(input logic [7:0] x);
        return {x[3:0], x[7:4]} ^ 8'h5A;
    endfunction

    assign iChromOut = pheno(oChromIn) ^ invMask;

    always @(posedge iClock) if (oMemWrite2 === 1'b1) writes2++;

    chromosome_eval_engine dut (
        .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iAck(iAck),
        .iInputSequence(iInputSequence), .iExpectedOutput(iExpectedOutput),
        .iValidMask(iValidMask), .iSequencesToProcess(iSequencesToProcess),
        .iDwellCycles(iDwellCycles), .iErrorLimit(iErrorLimit), .iCountMode(iCountMode),
        .oChromIn(oChromIn), .iChromOut(iChromOut), .oClearChrom(oClearChrom),
        .oReady(oReady), .oDone(oDone), .oAborted(oAborted), .oLogOverflow(oLogOverflow),
        .oState(oState), .oErrorSums(oErrorSums), .oTotalError(oTotalError),
        .oRetriesUsed(oRetriesUsed), .oMemAddr(oMemAddr), .oMemData(oMemData),
        .oMemWrite(oMemWrite)
    );

    chromosome_eval_engine #(.ADDR_W(6)) dut2 (
        .iClock(iClock), .iReset_n(iReset_n), .iStart(iStart), .iAck(iAck),
        .iInputSequence(iInputSequence), .iExpectedOutput(iExpectedOutput),
        .iValidMask(iValidMask), .iSequencesToProcess(iSequencesToProcess),
        .iDwellCycles(iDwellCycles), .iErrorLimit(iErrorLimit), .iCountMode(iCountMode),
        .oChromIn(oChromIn2), .iChromOut(iChromOut), .oClearChrom(oClearChrom2),
        .oReady(oReady2), .oDone(oDone2), .oAborted(oAborted2), .oLogOverflow(oLogOverflow2),
        .oState(oState2), .oErrorSums(oErrorSums2), .oTotalError(oTotalError2),
        .oRetriesUsed(oRetriesUsed2), .oMemAddr(oMemAddr2), .oMemData(oMemData2),
        .oMemWrite(oMemWrite2)
    );

    task automatic set_mask(input logic clearBit3);
        for (int k = 0; k < MS; k++)
            iValidMask[k*OW +: OW] = clearBit3 ? 8'hF7 : 8'hFF;
    endtask

    // Runs one evaluation. At cycle 'poke' (if reached) iStart is pulsed and
    // the config inputs are changed; neither may affect the running job.
    task automatic run_case(input string name, input int n, input int d,
                            input logic [34:0] lim, input logic mode,
                            input int poke, input exp_t e);
        exp_t got;
        int cyc;
        sb.push_back(e);
        iSequencesToProcess = 8'(n);
        iDwellCycles        = 16'(d);
        iErrorLimit         = lim;
        iCountMode          = mode;
        iStart = 1'b1;
        @(posedge iClock); #1;
        iStart = 1'b0;
        cyc = 1;
        while (oDone !== 1'b1 && cyc < 5000) begin
            iStart = (cyc == poke);
            if (cyc == poke) begin
                iSequencesToProcess = 8'd1;
                iDwellCycles        = 16'd5;
                iCountMode          = ~mode;
            end
            @(posedge iClock); #1;
            cyc++;
        end
        iStart = 1'b0;
        got = sb.pop_front();
        nTests++;
        if (cyc !== got.lat) begin
            nFail++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, got.lat);
        end
        nTests++;
        if (oTotalError !== got.total) begin
            nFail++;
            $display("FAIL %s total: got %0d expected %0d", name, oTotalError, got.total);
        end
        nTests++;
        if (oErrorSums[3*EW +: EW] !== got.err3) begin
            nFail++;
            $display("FAIL %s err3: got %0d expected %0d", name, oErrorSums[3*EW +: EW], got.err3);
        end
        nTests++;
        if (oAborted !== got.aborted) begin
            nFail++;
            $display("FAIL %s aborted: got %0b expected %0b", name, oAborted, got.aborted);
        end
        nTests++;
        if (oRetriesUsed !== got.retries) begin
            nFail++;
            $display("FAIL %s retries: got %0d expected %0d", name, oRetriesUsed, got.retries);
        end
        nTests++;
        if (oMemAddr !== got.addr) begin
            nFail++;
            $display("FAIL %s memaddr: got %0d expected %0d", name, oMemAddr, got.addr);
        end
        iAck = 1'b1;
        @(posedge iClock); #1;
        iAck = 1'b0;
        nTests++;
        if (oReady !== 1'b1 || oTotalError !== got.total) begin
            nFail++;
            $display("FAIL %s idle_hold: got ready=%0b total=%0d expected ready=1 total=%0d",
                     name, oReady, oTotalError, got.total);
        end
    endtask

    task automatic test_reset();
        nTests++;
        if (oReady !== 1'b1 || oState !== 3'd0 || oDone !== 1'b0 || oTotalError !== 35'd0
            || oMemAddr !== 15'd0 || oChromIn !== 8'd0 || oMemWrite !== 1'b0) begin
            nFail++;
            $display("FAIL reset: got ready=%0b state=%0d done=%0b total=%0d addr=%0d expected 1,0,0,0,0",
                     oReady, oState, oDone, oTotalError, oMemAddr);
        end
    endtask

    task automatic test_echo();
        invMask = 8'h00;
        run_case("echo", 4, 100, 35'd0, 1'b0, -1, '{1217, 35'd0, 32'd0, 1'b0, 2'd2, 15'd400});
    endtask

    task automatic test_bit3_mode0();
        invMask = 8'h08;
        run_case("bit3_mode0", 4, 100, 35'd0, 1'b0, -1, '{407, 35'd4, 32'd4, 1'b0, 2'd0, 15'd400});
    endtask

    task automatic test_bit3_mode1();
        invMask = 8'h08;
        run_case("bit3_mode1", 4, 100, 35'd0, 1'b1, -1, '{407, 35'd360, 32'd360, 1'b0, 2'd0, 15'd400});
    endtask

    task automatic test_masked();
        invMask = 8'h08;
        set_mask(1'b1);
        run_case("masked", 4, 100, 35'd0, 1'b1, -1, '{1217, 35'd0, 32'd0, 1'b0, 2'd2, 15'd400});
        set_mask(1'b0);
    endtask

    task automatic test_abort();
        invMask = 8'hFF;
        run_case("abort", 4, 100, 35'd2, 1'b0, -1, '{103, 35'd8, 32'd1, 1'b1, 2'd0, 15'd100});
    endtask

    task automatic test_overflow();
        invMask = 8'h08;
        writes2 = 0;
        run_case("ovf_run", 1, 100, 35'd0, 1'b0, -1, '{104, 35'd1, 32'd1, 1'b0, 2'd0, 15'd100});
        nTests++;
        if (writes2 !== 64) begin
            nFail++;
            $display("FAIL ovf_writes: got %0d expected 64", writes2);
        end
        nTests++;
        if (oMemAddr2 !== 6'd63 || oLogOverflow2 !== 1'b1) begin
            nFail++;
            $display("FAIL ovf_flag: got addr=%0d flag=%0b expected addr=63 flag=1", oMemAddr2, oLogOverflow2);
        end
        // A fresh start (N=0 here) must clear the overflow state.
        run_case("n_zero", 0, 100, 35'd0, 1'b0, -1, '{1, 35'd0, 32'd0, 1'b0, 2'd0, 15'd0});
        nTests++;
        if (oLogOverflow2 !== 1'b0 || oMemAddr2 !== 6'd0) begin
            nFail++;
            $display("FAIL ovf_clear: got addr=%0d flag=%0b expected addr=0 flag=0", oMemAddr2, oLogOverflow2);
        end
    endtask

    task automatic test_clamp();
        invMask = 8'h00;
        run_case("clamp", 200, 0, 35'd0, 1'b0, -1, '{389, 35'd0, 32'd0, 1'b0, 2'd2, 15'd64});
    endtask

    task automatic test_start_in_sample();
        invMask = 8'h08;
        run_case("start_in_sample", 4, 100, 35'd0, 1'b1, 50, '{407, 35'd360, 32'd360, 1'b0, 2'd0, 15'd400});
    endtask

    task automatic test_reset_mid();
        invMask = 8'h08;
        iSequencesToProcess = 8'd4;
        iDwellCycles        = 16'd20;
        iErrorLimit         = 35'd0;
        iCountMode          = 1'b1;
        iStart = 1'b1;
        @(posedge iClock); #1;
        iStart = 1'b0;
        for (int c = 1; c < 50; c++) begin
            @(posedge iClock); #1;
        end
        nTests++;
        if (oState !== 3'd3 || oTotalError !== 35'd20) begin
            nFail++;
            $display("FAIL reset_mid_pre: got state=%0d total=%0d expected state=3 total=20", oState, oTotalError);
        end
        iReset_n = 1'b0;
        #1;
        nTests++;
        if (oState !== 3'd0 || oTotalError !== 35'd0 || oReady !== 1'b1 || oMemAddr !== 15'd0) begin
            nFail++;
            $display("FAIL reset_mid: got state=%0d total=%0d ready=%0b addr=%0d expected 0,0,1,0",
                     oState, oTotalError, oReady, oMemAddr);
        end
        #2;
        iReset_n = 1'b1;
        @(posedge iClock); #1;
    endtask

    initial begin
        iReset_n = 1'b0;
        iStart = 1'b0;
        iAck = 1'b0;
        invMask = 8'h00;
        iSequencesToProcess = 8'd0;
        iDwellCycles = 16'd0;
        iErrorLimit = '0;
        iCountMode = 1'b0;
        for (int k = 0; k < MS; k++) begin
            iInputSequence[k*IW +: IW]  = 8'(k * 37 + 11);
            iExpectedOutput[k*OW +: OW] = pheno(8'(k * 37 + 11));
        end
        set_mask(1'b0);
        repeat (3) @(posedge iClock);
        #1;
        test_reset();
        iReset_n = 1'b1;
        @(posedge iClock); #1;
        test_echo();
        test_bit3_mode0();
        test_bit3_mode1();
        test_masked();
        test_abort();
        test_overflow();
        test_clamp();
        test_start_in_sample();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/chromosome_eval_engine.md
Name: chromosome_eval_engine

Overview:
- Parametrised successor to the fixed 8-bit chromosome processing state machine.
- Drives an external phenotype with a stored input sequence and samples its outputs for a programmable dwell time per vector.
- Accumulates per-output-bit error sums in one of two counting modes, retries perfect chromosomes, and aborts early past an error limit.
- Logs every sampled cycle to a trace memory; sits between the GA controller and the phenotype.

Parameters:
- IN_WIDTH, 8, phenotype input width.
- OUT_WIDTH, 8, phenotype output width (number of error channels).
- MAX_SEQ, 64, maximum stored vectors.
- ERR_W, 32, width of each error sum.
- ADDR_W, 15, trace memory address width.
- CYCLES_TO_IGNORE, 10, settle cycles not sampled at the start of each dwell.
- NUM_RETRIES, 2, extra passes run when a pass scores zero.

Ports:
- iClock  in  1  sole clock, rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- iStart  in  1  start request, sampled in IDLE only.
- iAck  in  1  result acknowledge, sampled in DONE only.
- iInputSequence  in  MAX_SEQ*IN_WIDTH  vector k at bits [k*IN_WIDTH +: IN_WIDTH].
- iExpectedOutput  in  MAX_SEQ*OUT_WIDTH  expected output per vector.
- iValidMask  in  MAX_SEQ*OUT_WIDTH  per-vector bit care mask (1 = compared).
- iSequencesToProcess  in  8  vector count N.
- iDwellCycles  in  16  cycles per vector D.
- iErrorLimit  in  ERR_W+3  abort threshold; 0 disables abort.
- iCountMode  in  1  0 = per-vector boolean, 1 = mismatching-cycle count.
- oChromIn  out  IN_WIDTH  registered drive to the phenotype.
- iChromOut  in  OUT_WIDTH  phenotype output.
- oClearChrom  out  1  forces phenotype description to zero.
- oReady, oDone, oAborted, oLogOverflow  out  1 each.
- oState  out  3  IDLE=0, CLEAR=1, SETTLE=2, SAMPLE=3, CHECK=4, DONE=5.
- oErrorSums  out  OUT_WIDTH*ERR_W  per-bit error sums.
- oTotalError  out  ERR_W+3  sum of oErrorSums.
- oRetriesUsed  out  2  completed retry passes.
- oMemAddr  out  ADDR_W  trace write address.
- oMemData  out  IN_WIDTH+8+2*OUT_WIDTH  {oChromIn, vector index zero-extended to 8, expected, iChromOut}.
- oMemWrite  out  1  trace write strobe.

Behaviour:
- Reset (asynchronous, any state): state IDLE; all registers and outputs 0 except oReady=1. Reset mid-run discards partial results.
- oReady = (state==IDLE); oDone = (state==DONE); oClearChrom = (state==CLEAR); oMemWrite = (state==SAMPLE && !oLogOverflow).
- IDLE:
  - On iStart, latch N (clamped to MAX_SEQ), D (0 treated as 1), limit and mode.
  - Clear sums, oAborted, oLogOverflow, retry count, vector index and address; go to CLEAR.
  - If the clamped N==0, go directly to DONE with zero results.
  - Latched config is immune to later input changes; iStart outside IDLE is ignored.
- CLEAR: one cycle, then SETTLE.
- SETTLE: one cycle. Register oChromIn <= vector[idx], zero the cycle counter c and the per-bit sampling sums s[b], then go to SAMPLE.
- SAMPLE: exactly D cycles, c = 0..D-1.
  - Mismatch m[b] = (iChromOut[b] ^ exp[idx][b]) & valid[idx][b]; sampled only when c >= CYCLES_TO_IGNORE, with s[b] saturating.
  - Each cycle writes the trace word at oMemAddr, then increments the address. At 2^ADDR_W-1 the write occurs, the address holds, and oLogOverflow sets, suppressing further writes.
  - On c==D-1 (this cycle's m included), commit err[b] += mode0 ? (s'[b]!=0) : s'[b], saturating at ERR_W.
  - Then, in priority order:
    - If limit!=0 and the new total >= limit, go to DONE with oAborted=1.
    - Else if idx==N-1, go to CHECK.
    - Else idx++ and go to SETTLE.
- CHECK:
  - If total==0 and retries<NUM_RETRIES: retries++, idx=0, address=0, oLogOverflow=0, go to SETTLE. The trace is overwritten and sums are retained (still zero).
  - Otherwise go to DONE.
- DONE: results held; on iAck go to IDLE. Results remain visible in IDLE until the next start.
- Latency, measured from the edge sampling iStart to oDone:
  - No abort: N(D+1)+3 cycles, plus N(D+1)+1 cycles per retry.
  - Abort in vector k (0-based): (k+1)(D+1)+2 cycles.

Test Plan:
- Bench echoes expected; N=4, D=100, mode0 -> all sums 0, oRetriesUsed=2, oDone at cycle 1217, final oMemAddr=400.
- Output bit 3 inverted, mask all ones, N=4, D=100:
  - mode0 -> err[3]=4, others 0, oDone at 407.
  - mode1 -> err[3]=360.
- Same stimulus with mask bit 3 cleared for all vectors -> all sums 0, retries run.
- All bits inverted, limit=2, N=4, D=100 -> oAborted=1, err[b]=1, oDone at cycle 103.
- ADDR_W=6, N=1, D=100 -> 64 writes, oMemAddr holds 63, oLogOverflow=1; then iAck and a new iStart clear the flag.
- Edge cases:
  - iReset_n low mid-SAMPLE -> immediate IDLE with zero sums.
  - N=0 -> DONE in 1 cycle.
  - N=200 -> clamped to 64.
  - iStart while in SAMPLE -> no effect.
